// File: rtl/mux_scan_scheduler.sv
// Round-robin scan sequencer for the 8-bit, 7-source sensor select mux.
// Grants requested channels 0-5 in turn, waits DWELL settle cycles, captures
// the mux output as a tagged sample, and parks the mux in error mode on a fault.
// Optional: define MUX_RANGE_CHECK_EN to trap captured values outside
// LIMIT_LO..LIMIT_HI (unsigned, inclusive) into the error state.
module mux_scan_scheduler #(
  parameter int unsigned DWELL    = 4,
  parameter logic [7:0]  LIMIT_LO = 8'h00,
  parameter logic [7:0]  LIMIT_HI = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] req,
  input  logic       error_in,
  input  logic       err_clear,
  input  logic [7:0] mux_out,
  output logic [4:0] select,
  output logic       sample_valid,
  output logic [2:0] sample_chan,
  output logic [7:0] sample_data,
  output logic       error_mode,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StDwell, StCapture, StError} state_e;

  localparam logic [4:0] SelError = 5'b11111;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [2:0] schan_q, schan_d;
  logic [7:0] sdata_q, sdata_d;

  logic       grant_found;
  logic [2:0] grant;
  logic [3:0] cand;
  logic       range_err;

  // One-hot-ish select code; channel 0 maps to the all-zero code.
  function automatic logic [4:0] chan_code(input logic [2:0] ch);
    unique case (ch)
      3'd1:    chan_code = 5'b00001;
      3'd2:    chan_code = 5'b00010;
      3'd3:    chan_code = 5'b00100;
      3'd4:    chan_code = 5'b01000;
      3'd5:    chan_code = 5'b10000;
      default: chan_code = 5'b00000;
    endcase
  endfunction

`ifdef MUX_RANGE_CHECK_EN
  assign range_err = (sdata_q < LIMIT_LO) || (sdata_q > LIMIT_HI);
`else
  logic unused_limits;
  assign unused_limits = ^{LIMIT_LO, LIMIT_HI};
  assign range_err     = 1'b0;
`endif

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant       = 3'd0;
    cand        = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      cand = {1'b0, last_q} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!grant_found && req[cand[2:0]]) begin
        grant_found = 1'b1;
        grant       = cand[2:0];
      end
    end
  end

  // Next-state logic: error beats capture, capture beats grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    schan_d = schan_q;
    sdata_d = sdata_q;
    unique case (state_q)
      StIdle: begin
        if (error_in) begin
          state_d = StError;
          sel_d   = SelError;
        end else if (enable && grant_found) begin
          state_d = StDwell;
          last_d  = grant;
          sel_d   = chan_code(grant);
          cnt_d   = 8'(DWELL - 1);
        end
      end
      StDwell: begin
        if (error_in) begin
          state_d = StError;
          sel_d   = SelError;
        end else if (cnt_q == 8'd0) begin
          state_d = StCapture;
          sdata_d = mux_out;
          schan_d = last_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCapture: begin
        if (error_in || range_err) begin
          state_d = StError;
          sel_d   = SelError;
        end else if (enable && grant_found) begin
          // Back-to-back grant, no idle bubble between samples.
          state_d = StDwell;
          last_d  = grant;
          sel_d   = chan_code(grant);
          cnt_d   = 8'(DWELL - 1);
        end else begin
          state_d = StIdle;
          sel_d   = 5'b00000;
        end
      end
      StError: begin
        if (err_clear && !error_in) begin
          state_d = StIdle;
          sel_d   = 5'b00000;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = 5'b00000;
      end
    endcase
  end

  // State and datapath registers; last_q resets to 5 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      sel_q   <= 5'b00000;
      last_q  <= 3'd5;
      schan_q <= 3'd0;
      sdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      schan_q <= schan_d;
      sdata_q <= sdata_d;
    end
  end

  assign select       = sel_q;
  assign sample_valid = (state_q == StCapture);
  assign sample_chan  = schan_q;
  assign sample_data  = sdata_q;
  assign error_mode   = (state_q == StError);
  assign busy         = (state_q == StDwell) || (state_q == StCapture);

endmodule
